// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller: state encoding,
// BCD digit limits and the MM:SS time record.
package microwave_pkg;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } mmss_t;

  localparam mmss_t EXPRESS_TIME = '{mt: 4'd0, mu: 4'd0, st: 4'd3, su: 4'd0};

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD MM:SS register with key shift-in, clear, preset and a
// borrow-chained decrement (seconds wrap 00->59, digits wrap 0->9).
module bcd_mmss_counter
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic [3:0] digit,
  input  logic       clear,
  input  logic       preset,
  input  mmss_t      preset_val,
  input  logic       dec,
  output mmss_t      mmss,
  output logic       zero
);

  mmss_t mmss_q, mmss_d;

  always_comb begin
    mmss_d = mmss_q;
    if (clear) begin
      mmss_d = '0;
    end else if (preset) begin
      mmss_d = preset_val;
    end else if (dec) begin
      // Never asked to decrement 00:00, so mt cannot underflow.
      if (mmss_q.su != 4'd0) begin
        mmss_d.su = mmss_q.su - 4'd1;
      end else begin
        mmss_d.su = BCD_NINE;
        if (mmss_q.st != 4'd0) begin
          mmss_d.st = mmss_q.st - 4'd1;
        end else begin
          mmss_d.st = BCD_FIVE;
          if (mmss_q.mu != 4'd0) begin
            mmss_d.mu = mmss_q.mu - 4'd1;
          end else begin
            mmss_d.mu = BCD_NINE;
            mmss_d.mt = mmss_q.mt - 4'd1;
          end
        end
      end
    end else if (shift_en) begin
      mmss_d = '{mt: mmss_q.mu, mu: mmss_q.st, st: mmss_q.su, su: digit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmss_q <= '0;
    end else begin
      mmss_q <= mmss_d;
    end
  end

  assign mmss = mmss_q;
  assign zero = (mmss_q == '0);

endmodule

// File: rtl/microwave_controller.sv
// Microwave sequencer: synchronizes keypad/button/door/tick inputs, runs the
// SET/COOK/PAUSE/DONE FSM and the BCD cook timer. Optional: EXPRESS_START_EN.
module microwave_controller
  import microwave_pkg::*;
#(
  parameter int unsigned DONE_HOLD_TICKS = 3,
  parameter int unsigned SYNC_STAGES     = 2  // must be >= 2
) (
  input  logic       Hz_100_clock,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic       enablen,
  output logic [3:0] mins_tens,
  output logic [3:0] mins_units,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_units,
  output logic       magnetron_on,
  output logic       done
);

  localparam int unsigned HoldW = (DONE_HOLD_TICKS > 1) ? $clog2(DONE_HOLD_TICKS) : 1;
  // Bit order: loadn, startn, stopn, clearn, pgt_1Hz, door_closed.
  localparam logic [5:0] SyncIdle = 6'b00_1111;

  logic [5:0] sync_q [SYNC_STAGES];
  logic [3:0] d_q    [SYNC_STAGES];
  logic [4:0] prev_q;
  logic [5:0] sync_out;
  logic [3:0] d_sync;

  always_ff @(posedge Hz_100_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SyncIdle;
        d_q[i]    <= '0;
      end
      prev_q <= SyncIdle[4:0];
    end else begin
      sync_q[0] <= {door_closed, pgt_1Hz, clearn, stopn, startn, loadn};
      d_q[0]    <= D;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
        d_q[i]    <= d_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1][4:0];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign d_sync   = d_q[SYNC_STAGES-1];

  logic key_ev, start_ev, stop_ev, clear_ev, tick_ev, door_ok;
  assign key_ev   = prev_q[0] & ~sync_out[0];
  assign start_ev = prev_q[1] & ~sync_out[1];
  assign stop_ev  = prev_q[2] & ~sync_out[2];
  assign clear_ev = prev_q[3] & ~sync_out[3];
  assign tick_ev  = ~prev_q[4] & sync_out[4];
  // Door is used as a level: an open door must pause cooking at any time.
  assign door_ok  = sync_out[5];

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             cnt_shift, cnt_clear, cnt_preset, cnt_dec;
  mmss_t            mmss;
  logic             zero;
  logic             last_second;

  assign last_second = (mmss == mmss_t'(16'h0001));

  always_comb begin
    state_d    = state_q;
    hold_d     = '0;
    cnt_shift  = 1'b0;
    cnt_clear  = 1'b0;
    cnt_preset = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      SET: begin
        if (clear_ev) begin
          cnt_clear = 1'b1;
        end else if (start_ev) begin
          if (door_ok && !zero) begin
            state_d = COOK;
          end
`ifdef EXPRESS_START_EN
          else if (door_ok) begin
            cnt_preset = 1'b1;
            state_d    = COOK;
          end
`endif
        end else if (key_ev && is_bcd(d_sync)) begin
          cnt_shift = 1'b1;
        end
      end
      COOK: begin
        if (!door_ok || stop_ev) begin
          state_d = PAUSE;
        end else if (tick_ev) begin
          cnt_dec = 1'b1;
          if (last_second) begin
            state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (stop_ev || clear_ev) begin
          state_d   = SET;
          cnt_clear = 1'b1;
        end else if (start_ev && door_ok) begin
          state_d = COOK;
        end
      end
      DONE: begin
        hold_d = hold_q;
        if (stop_ev || clear_ev || !door_ok || key_ev) begin
          state_d = SET;
        end else if (tick_ev) begin
          if (hold_q == HoldW'(DONE_HOLD_TICKS - 1)) begin
            state_d = SET;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Hz_100_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= SET;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  bcd_mmss_counter u_counter (
    .clk        (Hz_100_clock),
    .rst_n      (resetn),
    .shift_en   (cnt_shift),
    .digit      (d_sync),
    .clear      (cnt_clear),
    .preset     (cnt_preset),
    .preset_val (EXPRESS_TIME),
    .dec        (cnt_dec),
    .mmss       (mmss),
    .zero       (zero)
  );

  // Decoded straight from state so an asynchronous reset drops them at once.
  assign enablen      = (state_q != SET);
  assign magnetron_on = (state_q == COOK);
  assign done         = (state_q == DONE);
  assign mins_tens    = mmss.mt;
  assign mins_units   = mmss.mu;
  assign secs_tens    = mmss.st;
  assign secs_units   = mmss.su;

endmodule

// File: tb/tb_microwave_controller.sv
// Self-checking bench for microwave_controller: cycle-level behavioural model
// plus directed scenarios with literal expectations.
module tb_microwave_controller;

  localparam int HOLD = 3;
  localparam int SYNC = 2;
  localparam int S_SET = 0, S_COOK = 1, S_PAUSE = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1, startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
  logic       door_closed = 1'b1, pgt = 1'b0;
  logic       enablen, magnetron_on, done;
  logic [3:0] mt, mu, st, su;

  always #5 clk = ~clk;

  microwave_controller #(.DONE_HOLD_TICKS(HOLD), .SYNC_STAGES(SYNC)) dut (
    .Hz_100_clock (clk),
    .resetn       (resetn),
    .D            (D),
    .loadn        (loadn),
    .pgt_1Hz      (pgt),
    .startn       (startn),
    .stopn        (stopn),
    .clearn       (clearn),
    .door_closed  (door_closed),
    .enablen      (enablen),
    .mins_tens    (mt),
    .mins_units   (mu),
    .secs_tens    (st),
    .secs_units   (su),
    .magnetron_on (magnetron_on),
    .done         (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int disp();
    return int'(mt) * 1000 + int'(mu) * 100 + int'(st) * 10 + int'(su);
  endfunction

  // ---------------- behavioural model ----------------
  // Time is kept as the decimal number MMSS; inputs are seen SYNC clocks late.
  typedef struct packed {
    logic       loadn, startn, stopn, clearn, pgt, door;
    logic [3:0] d;
  } snap_t;

  snap_t hist [SYNC+1];
  int    m_state, m_val, m_hold;
  int    n_state, n_val, n_hold;

  always_comb begin
    snap_t cur, old;
    logic  k, sa, sp, cl, tk;
    cur = hist[SYNC-1];
    old = hist[SYNC];
    k  = old.loadn  & ~cur.loadn;
    sa = old.startn & ~cur.startn;
    sp = old.stopn  & ~cur.stopn;
    cl = old.clearn & ~cur.clearn;
    tk = ~old.pgt   & cur.pgt;
    n_state = m_state;
    n_val   = m_val;
    n_hold  = 0;
    case (m_state)
      S_SET: begin
        if (cl) n_val = 0;
        else if (sa) begin
          if (cur.door && m_val != 0) n_state = S_COOK;
`ifdef EXPRESS_START_EN
          else if (cur.door) begin
            n_val   = 30;
            n_state = S_COOK;
          end
`endif
        end else if (k && cur.d <= 4'd9) n_val = (m_val * 10 + int'(cur.d)) % 10000;
      end
      S_COOK: begin
        if (!cur.door || sp) n_state = S_PAUSE;
        else if (tk) begin
          n_val = (m_val % 100 == 0) ? m_val - 41 : m_val - 1;
          if (n_val == 0) n_state = S_DONE;
        end
      end
      S_PAUSE: begin
        if (sp || cl) begin
          n_state = S_SET;
          n_val   = 0;
        end else if (sa && cur.door) n_state = S_COOK;
      end
      default: begin
        n_hold = m_hold;
        if (sp || cl || !cur.door || k) n_state = S_SET;
        else if (tk) begin
          if (m_hold + 1 >= HOLD) n_state = S_SET;
          else n_hold = m_hold + 1;
        end
      end
    endcase
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i <= SYNC; i++) hist[i] <= '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
      m_state <= S_SET;
      m_val   <= 0;
      m_hold  <= 0;
    end else begin
      hist[0] <= '{loadn, startn, stopn, clearn, pgt, door_closed, D};
      for (int i = 1; i <= SYNC; i++) hist[i] <= hist[i-1];
      m_state <= n_state;
      m_val   <= n_val;
      m_hold  <= n_hold;
    end
  end

  always @(negedge clk) begin
    if (resetn && chk_on) begin
      check("model mins_tens", int'(mt), m_val / 1000);
      check("model mins_units", int'(mu), (m_val / 100) % 10);
      check("model secs_tens", int'(st), (m_val / 10) % 10);
      check("model secs_units", int'(su), m_val % 10);
      check("model magnetron_on", int'(magnetron_on), int'(m_state == S_COOK));
      check("model done", int'(done), int'(m_state == S_DONE));
      check("model enablen", int'(enablen), int'(m_state != S_SET));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    D = d; loadn = 1'b0; clks(2);
    loadn = 1'b1; clks(4);
  endtask

  task automatic press_start();
    startn = 1'b0; clks(2); startn = 1'b1; clks(4);
  endtask

  task automatic press_stop();
    stopn = 1'b0; clks(2); stopn = 1'b1; clks(4);
  endtask

  task automatic press_clear();
    clearn = 1'b0; clks(2); clearn = 1'b1; clks(4);
  endtask

  task automatic tick();
    pgt = 1'b1; clks(2); pgt = 1'b0; clks(4);
  endtask

  initial begin
    clks(3);
    check("reset display", disp(), 0);
    check("reset enablen", int'(enablen), 0);
    check("reset magnetron", int'(magnetron_on), 0);
    check("reset done", int'(done), 0);
    resetn = 1'b1;
    chk_on = 1'b1;
    clks(3);

    // 1: entry and start latency
    key(4'd1); key(4'd2); key(4'd3); key(4'd0);
    check("t1 display 12:30", disp(), 1230);
    check("t1 enablen in SET", int'(enablen), 0);
    startn = 1'b0;
    clks(2);
    check("t1 magnetron before 3 clocks", int'(magnetron_on), 0);
    clks(1);
    check("t1 magnetron after 3 clocks", int'(magnetron_on), 1);
    check("t1 enablen after 3 clocks", int'(enablen), 1);
    startn = 1'b1; clks(4);
    press_stop(); press_stop();
    check("stop in PAUSE zeroes", disp(), 0);

    // 2: borrow and done sequence
    key(4'd1); key(4'd0); key(4'd0); press_start();
    tick();
    check("t2 01:00 -> 00:59", disp(), 59);
    for (int i = 0; i < 20; i++) tick();
    check("t2 twenty ticks -> 00:39", disp(), 39);
    press_stop(); press_stop();
    key(4'd1); press_start(); tick();
    check("t2 reached 00:00", disp(), 0);
    check("t2 done asserted", int'(done), 1);
    tick(); tick();
    check("t2 done held 2 ticks", int'(done), 1);
    tick();
    check("t2 done released", int'(done), 0);
    check("t2 back in SET", int'(enablen), 0);

    // 3: door pause and resume
    key(4'd4); key(4'd5); press_start();
    door_closed = 1'b0; clks(6);
    check("t3 paused time", disp(), 45);
    check("t3 paused magnetron", int'(magnetron_on), 0);
    door_closed = 1'b1; clks(4); press_start();
    check("t3 resumed magnetron", int'(magnetron_on), 1);
    check("t3 resumed time", disp(), 45);

    // 4: simultaneous door open + start + tick, then key during cook
    door_closed = 1'b0; startn = 1'b0; pgt = 1'b1; clks(2);
    startn = 1'b1; pgt = 1'b0; clks(4);
    check("t4 paused only", int'(magnetron_on), 0);
    check("t4 time unchanged", disp(), 45);
    door_closed = 1'b1; clks(4); press_start();
    key(4'd7);
    check("t4 key ignored in COOK", disp(), 45);
    tick();
    check("t4 tick 00:44", disp(), 44);
    press_stop(); press_stop();

    // boundaries: oversized seconds, minute-tens borrow, overflow, clear
    key(4'd7); key(4'd5); press_start(); tick();
    check("00:75 -> 00:74", disp(), 74);
    press_stop(); press_stop();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0); press_start(); tick();
    check("10:00 -> 09:59", disp(), 959);
    press_stop(); press_stop();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    check("fifth key drops oldest", disp(), 2345);
    press_clear();
    check("clear zeroes", disp(), 0);

    // 5: start at 00:00 and non-BCD key
    key(4'hC);
    check("t5 non-BCD key ignored", disp(), 0);
    press_start();
`ifdef EXPRESS_START_EN
    check("t5 express time", disp(), 30);
    check("t5 express cooking", int'(magnetron_on), 1);
    press_stop(); press_stop();
`else
    check("t5 zero start ignored", int'(magnetron_on), 0);
    check("t5 still SET", int'(enablen), 0);
`endif

    // 6: asynchronous reset mid-cook
    key(4'd5); key(4'd0); key(4'd0); press_start();
    check("t6 cooking at 05:00", int'(magnetron_on), 1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("t6 async magnetron drop", int'(magnetron_on), 0);
    check("t6 async display clear", disp(), 0);
    check("t6 async enablen", int'(enablen), 0);
    clks(2);
    resetn = 1'b1;
    clks(4);
    check("t6 SET after reset", int'(enablen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
